wx_mem_responder: RTL and testbench
===================================

WX_MEM_RESPONDER -- requirements
Module: wx_mem_responder

Interface
REQ-001 SHALL have parameters (name, default, meaning):
  - W_ADDR_LEN, 20, weight address width
  - X_ADDR_LEN, 10, activation address width
  - W_SEL_LEN, 2, weight bank select width
  - X_SEL_LEN, 2, activation bank select width
  - W_DEPTH, 1048576, bits per weight bank
  - X_DEPTH, 1024, bits per activation bank
REQ-002 SHALL have ports (name direction width meaning):
  - clk in 1 sole clock, rising edge
  - rst in 1 reset, synchronous, active-high
  - w_addr in W_ADDR_LEN weight bit address
  - w_sel in W_SEL_LEN weight bank (layer) select
  - w_rq in 1 weight read request
  - w_wq in 1 weight write request
  - w_data out 1 weight read data
  - x_addr in X_ADDR_LEN activation bit address
  - x_sel in X_SEL_LEN activation bank select
  - x_rq in 1 activation read request
  - x_wq in 1 activation write request
  - x_data out 1 activation read data
  - wx_write in 1 write data bit, shared by w and x write ports
  - ld_valid in 1 preload beat valid
  - ld_ready out 1 preload beat accepted
  - ld_target in 1 preload target: 0 = weight, 1 = activation
  - ld_sel in 2 preload bank
  - ld_addr in W_ADDR_LEN preload address (low X_ADDR_LEN bits used for activation)
  - ld_bit in 1 preload data
  - ld_done in 1 end of preload, single-cycle pulse
  - mem_ready out 1 high only in SERVE
  - req_err out 1 sticky: request seen outside SERVE
  - range_err out 1 sticky: address >= depth
  - coll_err out 1 sticky: rq and wq high together on one port

Function
REQ-003 SHALL implement FSM CLEAR -> LOAD -> SERVE; SERVE is terminal until rst.
REQ-004 CLEAR SHALL zero all four activation banks at one address per cycle, all banks in parallel, taking exactly X_DEPTH cycles, then enter LOAD; weight banks are not cleared.
REQ-005 LOAD SHALL hold ld_ready = 1 and write ld_bit to the selected bank/address on every cycle with ld_valid = 1.
REQ-006 LOAD SHALL move to SERVE on the cycle after ld_done = 1; a beat with ld_valid in the same cycle as ld_done SHALL still be written.
REQ-007 Preload beat with address >= depth of its target SHALL be dropped and SHALL set range_err.
REQ-008 In SERVE, ld_ready SHALL be 0 and ld_valid SHALL be ignored without error.
REQ-009 In SERVE, read latency SHALL be 1 cycle: w_rq/x_rq sampled at edge N -> w_data/x_data valid after edge N+1.
REQ-010 Read data SHALL hold its last value while no read is requested.
REQ-011 In SERVE, w_wq/x_wq SHALL write wx_write to (sel, addr) at the sampling edge.
REQ-012 When rq and wq are both high on one port, both SHALL proceed: read returns the pre-write (old) value, the write commits, and coll_err is set.
REQ-013 A read at address >= depth SHALL return 0 and set range_err; a write at address >= depth SHALL be ignored and set range_err.
REQ-014 The w and x ports SHALL be fully independent; both may operate in the same cycle.
REQ-015 Any rq/wq in CLEAR or LOAD SHALL be ignored (no memory change, data outputs unchanged) and SHALL set req_err.
REQ-016 Sticky flags SHALL clear only on rst.

Reset
REQ-017 rst SHALL be sampled on clk only; while high: state = CLEAR, clear address = 0, w_data = 0, x_data = 0, ld_ready = 0, mem_ready = 0, all error flags = 0.
REQ-018 rst asserted mid-CLEAR, mid-LOAD or mid-SERVE SHALL restart CLEAR; weight contents are undefined-preserved (not cleared), activation contents are re-zeroed.

Verification
REQ-019 The bench SHALL cover:
  - Reset release: mem_ready = 0 for exactly X_DEPTH cycles, then ld_ready = 1; x read of any bank after SERVE returns 0.
  - Preload w bank 1 addr 5 = 1, ld_done -> SERVE; w_rq sel = 1 addr 5 at edge N -> w_data = 1 after edge N+1; addr 6 -> 0.
  - x_wq sel = 2 addr 1023 with wx_write = 1, next cycle x_rq -> x_data = 1; no flags set.
  - x_rq + x_wq same cycle on an address holding 0 with wx_write = 1 -> x_data = 0, coll_err = 1, next read returns 1.
  - x_rq during LOAD -> req_err = 1, x_data unchanged; w_rq with addr = W_DEPTH -> w_data = 0, range_err = 1.
  - rst pulse mid-SERVE after x writes -> CLEAR repeats, flags = 0, prior x data reads 0, preloaded weights are not re-zeroed.

Source files
------------

// File: rtl/wx_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : wx_mem_responder_if
// Description : Bus bundle for the weight/activation bit-memory responder.
//               Groups the weight port, activation port, shared write bit,
//               preload channel and status flags.
//               slave  modport : the responder (wx_mem_responder)
//               master modport : the requester driving reads/writes/preloads
// Revision    : 1.0 - initial release
// ============================================================================
interface wx_mem_responder_if #(
    parameter int W_ADDR_LEN = 20,
    parameter int X_ADDR_LEN = 10,
    parameter int W_SEL_LEN  = 2,
    parameter int X_SEL_LEN  = 2
);
    // weight port
    logic [W_ADDR_LEN-1:0] w_addr;
    logic [W_SEL_LEN-1:0]  w_sel;
    logic                  w_rq;
    logic                  w_wq;
    logic                  w_data;
    // activation port
    logic [X_ADDR_LEN-1:0] x_addr;
    logic [X_SEL_LEN-1:0]  x_sel;
    logic                  x_rq;
    logic                  x_wq;
    logic                  x_data;
    // shared write data
    logic                  wx_write;
    // preload channel
    logic                  ld_valid;
    logic                  ld_ready;
    logic                  ld_target;
    logic [1:0]            ld_sel;
    logic [W_ADDR_LEN-1:0] ld_addr;
    logic                  ld_bit;
    logic                  ld_done;
    // status
    logic                  mem_ready;
    logic                  req_err;
    logic                  range_err;
    logic                  coll_err;

    modport slave (
        input  w_addr, w_sel, w_rq, w_wq,
        output w_data,
        input  x_addr, x_sel, x_rq, x_wq,
        output x_data,
        input  wx_write,
        input  ld_valid, ld_target, ld_sel, ld_addr, ld_bit, ld_done,
        output ld_ready,
        output mem_ready, req_err, range_err, coll_err
    );

    modport master (
        output w_addr, w_sel, w_rq, w_wq,
        input  w_data,
        output x_addr, x_sel, x_rq, x_wq,
        input  x_data,
        output wx_write,
        output ld_valid, ld_target, ld_sel, ld_addr, ld_bit, ld_done,
        input  ld_ready,
        input  mem_ready, req_err, range_err, coll_err
    );
endinterface
`default_nettype wire

// File: rtl/wx_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : wx_mem_responder
// Description : Bit-addressed weight and activation memory responder.
//               After reset it zeroes the activation banks (CLEAR), accepts a
//               preload stream (LOAD), then serves independent 1-cycle-latency
//               reads and writes on the weight and activation ports (SERVE).
// Ports       : clk - rising-edge clock
//               rst - synchronous active-high reset
//               bus - wx_mem_responder_if.slave (w/x ports, preload, flags)
// Revision    : 1.0 - initial release
// ============================================================================
module wx_mem_responder #(
    parameter int W_ADDR_LEN = 20,
    parameter int X_ADDR_LEN = 10,
    parameter int W_SEL_LEN  = 2,
    parameter int X_SEL_LEN  = 2,
    parameter int W_DEPTH    = 1048576,
    parameter int X_DEPTH    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    wx_mem_responder_if.slave     bus
);
    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SERVE = 2'd2;

    localparam int NW    = 1 << W_SEL_LEN;
    localparam int NX    = 1 << X_SEL_LEN;
    localparam int W_IDX = $clog2(W_DEPTH);
    localparam int X_IDX = $clog2(X_DEPTH);

    // Limits widened by one bit so a depth of 2**ADDR_LEN is representable.
    localparam logic [W_ADDR_LEN:0]   C_W_LIM  = (W_ADDR_LEN+1)'(W_DEPTH);
    localparam logic [X_ADDR_LEN:0]   C_X_LIM  = (X_ADDR_LEN+1)'(X_DEPTH);
    localparam logic [X_ADDR_LEN-1:0] C_X_LAST = X_ADDR_LEN'(X_DEPTH - 1);
    localparam logic [X_ADDR_LEN-1:0] C_ONE    = X_ADDR_LEN'(1);

    logic [1:0]            state_q, state_d;
    logic [X_ADDR_LEN-1:0] clr_addr_q, clr_addr_d;
    logic                  w_rd_vld_q, w_rd_bit_q, w_data_q;
    logic                  x_rd_vld_q, x_rd_bit_q, x_data_q;
    logic                  req_err_q, range_err_q, coll_err_q;

    logic                  w_mem_q [NW][W_DEPTH];
    logic [NX-1:0]         x_bank_bit;

    logic                  is_clear, is_load, is_serve;
    logic                  w_inrng, x_inrng, ld_inrng, any_req;
    logic [X_ADDR_LEN-1:0] ld_x_addr;

    assign is_clear  = (state_q == S_CLEAR);
    assign is_load   = (state_q == S_LOAD);
    assign is_serve  = (state_q == S_SERVE);
    assign w_inrng   = ({1'b0, bus.w_addr} < C_W_LIM);
    assign x_inrng   = ({1'b0, bus.x_addr} < C_X_LIM);
    assign ld_x_addr = bus.ld_addr[X_ADDR_LEN-1:0];
    assign ld_inrng  = bus.ld_target ? ({1'b0, ld_x_addr} < C_X_LIM)
                                     : ({1'b0, bus.ld_addr} < C_W_LIM);
    assign any_req   = bus.w_rq | bus.w_wq | bus.x_rq | bus.x_wq;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            S_CLEAR: begin
                clr_addr_d = clr_addr_q + C_ONE;
                if (clr_addr_q == C_X_LAST) begin
                    clr_addr_d = '0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD:  if (bus.ld_done) state_d = S_SERVE;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_CLEAR;
            clr_addr_q  <= '0;
            w_rd_vld_q  <= 1'b0;
            w_rd_bit_q  <= 1'b0;
            w_data_q    <= 1'b0;
            x_rd_vld_q  <= 1'b0;
            x_rd_bit_q  <= 1'b0;
            x_data_q    <= 1'b0;
            req_err_q   <= 1'b0;
            range_err_q <= 1'b0;
            coll_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            // Stage 1 captures the pre-write value at the request edge;
            // stage 2 presents it one cycle later and otherwise holds.
            w_rd_vld_q <= is_serve & bus.w_rq;
            w_rd_bit_q <= w_inrng ? w_mem_q[bus.w_sel][bus.w_addr[W_IDX-1:0]] : 1'b0;
            x_rd_vld_q <= is_serve & bus.x_rq;
            x_rd_bit_q <= x_inrng ? x_bank_bit[bus.x_sel] : 1'b0;
            if (w_rd_vld_q) w_data_q <= w_rd_bit_q;
            if (x_rd_vld_q) x_data_q <= x_rd_bit_q;

            if (!is_serve && any_req)
                req_err_q <= 1'b1;
            if (is_load && bus.ld_valid && !ld_inrng)
                range_err_q <= 1'b1;
            if (is_serve && (((bus.w_rq | bus.w_wq) && !w_inrng) ||
                             ((bus.x_rq | bus.x_wq) && !x_inrng)))
                range_err_q <= 1'b1;
            if (is_serve && ((bus.w_rq & bus.w_wq) | (bus.x_rq & bus.x_wq)))
                coll_err_q <= 1'b1;
        end
    end

    // Weight storage: never cleared, written by preload or the w port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (is_load && bus.ld_valid && !bus.ld_target && ld_inrng)
                w_mem_q[bus.ld_sel][bus.ld_addr[W_IDX-1:0]] <= bus.ld_bit;
            else if (is_serve && bus.w_wq && w_inrng)
                w_mem_q[bus.w_sel][bus.w_addr[W_IDX-1:0]] <= bus.wx_write;
        end
    end

    // Activation storage: one array per bank so CLEAR can zero every bank
    // at the same address in a single cycle.
    for (genvar b = 0; b < NX; b++) begin : g_xbank
        localparam logic [X_SEL_LEN-1:0] C_BANK    = X_SEL_LEN'(b);
        localparam logic [1:0]           C_LD_BANK = 2'(b);
        logic mem_q [X_DEPTH];

        always_ff @(posedge clk) begin
            if (!rst) begin
                if (is_clear)
                    mem_q[clr_addr_q[X_IDX-1:0]] <= 1'b0;
                else if (is_load && bus.ld_valid && bus.ld_target && ld_inrng &&
                         bus.ld_sel == C_LD_BANK)
                    mem_q[ld_x_addr[X_IDX-1:0]] <= bus.ld_bit;
                else if (is_serve && bus.x_wq && x_inrng && bus.x_sel == C_BANK)
                    mem_q[bus.x_addr[X_IDX-1:0]] <= bus.wx_write;
            end
        end

        assign x_bank_bit[b] = mem_q[bus.x_addr[X_IDX-1:0]];
    end

    assign bus.w_data    = w_data_q;
    assign bus.x_data    = x_data_q;
    assign bus.ld_ready  = is_load;
    assign bus.mem_ready = is_serve;
    assign bus.req_err   = req_err_q;
    assign bus.range_err = range_err_q;
    assign bus.coll_err  = coll_err_q;
endmodule
`default_nettype wire

// File: tb/tb_wx_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_wx_mem_responder
// Description : Self-checking bench for wx_mem_responder. A rule-level model
//               predicts every output each cycle; directed sequences add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wx_mem_responder;
    localparam int WAL = 20;
    localparam int XAL = 10;
    localparam int WSL = 2;
    localparam int XSL = 2;
    localparam int WD  = 4096;   // shrunk so addr = W_DEPTH is reachable
    localparam int XD  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wx_mem_responder_if #(.W_ADDR_LEN(WAL), .X_ADDR_LEN(XAL),
                          .W_SEL_LEN(WSL), .X_SEL_LEN(XSL)) bus ();

    wx_mem_responder #(.W_ADDR_LEN(WAL), .X_ADDR_LEN(XAL), .W_SEL_LEN(WSL),
                       .X_SEL_LEN(XSL), .W_DEPTH(WD), .X_DEPTH(XD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit wm [int];            // weights keyed by sel*WD+addr (written cells only)
    bit xm [4][XD];
    int phase   = 0;         // 0 clear, 1 load, 2 serve
    int clr_cnt = 0;
    bit ew, ex, e_req, e_rng, e_coll;
    bit pw_v, pw_b, px_v, px_b;

    function automatic bit wread(input int k);
        return wm.exists(k) ? wm[k] : 1'b0;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            phase = 0; clr_cnt = 0;
            ew = 0; ex = 0; pw_v = 0; px_v = 0;
            e_req = 0; e_rng = 0; e_coll = 0;
        end else begin
            if (pw_v) ew = pw_b;
            if (px_v) ex = px_b;
            pw_v = 0; px_v = 0;
            if (phase != 2 && (bus.w_rq || bus.w_wq || bus.x_rq || bus.x_wq))
                e_req = 1;
            if (phase == 0) begin
                clr_cnt++;
                if (clr_cnt == XD) begin
                    foreach (xm[b, a]) xm[b][a] = 1'b0;
                    phase = 1;
                end
            end else if (phase == 1) begin
                if (bus.ld_valid) begin
                    if (bus.ld_target) begin
                        if (int'(bus.ld_addr[XAL-1:0]) < XD)
                            xm[bus.ld_sel][int'(bus.ld_addr[XAL-1:0])] = bus.ld_bit;
                        else e_rng = 1;
                    end else begin
                        if (int'(bus.ld_addr) < WD)
                            wm[int'(bus.ld_sel)*WD + int'(bus.ld_addr)] = bus.ld_bit;
                        else e_rng = 1;
                    end
                end
                if (bus.ld_done) phase = 2;
            end else begin
                if (bus.w_rq) begin
                    pw_v = 1;
                    if (int'(bus.w_addr) < WD) pw_b = wread(int'(bus.w_sel)*WD + int'(bus.w_addr));
                    else begin pw_b = 0; e_rng = 1; end
                end
                if (bus.w_wq) begin
                    if (int'(bus.w_addr) < WD) wm[int'(bus.w_sel)*WD + int'(bus.w_addr)] = bus.wx_write;
                    else e_rng = 1;
                end
                if (bus.w_rq && bus.w_wq) e_coll = 1;
                if (bus.x_rq) begin
                    px_v = 1;
                    if (int'(bus.x_addr) < XD) px_b = xm[bus.x_sel][int'(bus.x_addr)];
                    else begin px_b = 0; e_rng = 1; end
                end
                if (bus.x_wq) begin
                    if (int'(bus.x_addr) < XD) xm[bus.x_sel][int'(bus.x_addr)] = bus.wx_write;
                    else e_rng = 1;
                end
                if (bus.x_rq && bus.x_wq) e_coll = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (started) begin
            chk1("w_data",    bus.w_data,    ew);
            chk1("x_data",    bus.x_data,    ex);
            chk1("ld_ready",  bus.ld_ready,  phase == 1);
            chk1("mem_ready", bus.mem_ready, phase == 2);
            chk1("req_err",   bus.req_err,   e_req);
            chk1("range_err", bus.range_err, e_rng);
            chk1("coll_err",  bus.coll_err,  e_coll);
        end
    end

    // ---------------- stimulus helpers (call right after a negedge) -------
    task automatic idle();
        bus.w_rq = 0; bus.w_wq = 0; bus.x_rq = 0; bus.x_wq = 0;
        bus.ld_valid = 0; bus.ld_done = 0;
    endtask

    task automatic w_rd(input logic [WSL-1:0] s, input logic [WAL-1:0] a, output logic d);
        bus.w_sel = s; bus.w_addr = a; bus.w_rq = 1;
        @(negedge clk); bus.w_rq = 0;
        @(negedge clk); d = bus.w_data;
    endtask

    task automatic x_rd(input logic [XSL-1:0] s, input logic [XAL-1:0] a, output logic d);
        bus.x_sel = s; bus.x_addr = a; bus.x_rq = 1;
        @(negedge clk); bus.x_rq = 0;
        @(negedge clk); d = bus.x_data;
    endtask

    task automatic x_wr(input logic [XSL-1:0] s, input logic [XAL-1:0] a, input logic v);
        bus.x_sel = s; bus.x_addr = a; bus.wx_write = v; bus.x_wq = 1;
        @(negedge clk); bus.x_wq = 0;
    endtask

    task automatic ld_beat(input logic t, input logic [1:0] s, input logic [WAL-1:0] a,
                           input logic v, input logic done);
        bus.ld_target = t; bus.ld_sel = s; bus.ld_addr = a; bus.ld_bit = v;
        bus.ld_valid = 1; bus.ld_done = done;
        @(negedge clk); bus.ld_valid = 0; bus.ld_done = 0;
    endtask

    // Counts cycles with ld_ready low starting at the release cycle.
    task automatic clear_len(output int n);
        n = 0;
        while (bus.ld_ready !== 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic d;
        int   n;
        idle();
        bus.w_sel = 0; bus.w_addr = 0; bus.x_sel = 0; bus.x_addr = 0;
        bus.wx_write = 0; bus.ld_target = 0; bus.ld_sel = 0; bus.ld_addr = 0; bus.ld_bit = 0;
        repeat (3) @(negedge clk);
        started = 1'b1;
        chk1("rst_mem_ready", bus.mem_ready, 1'b0);
        chk1("rst_ld_ready",  bus.ld_ready,  1'b0);
        chk1("rst_w_data",    bus.w_data,    1'b0);
        chk1("rst_x_data",    bus.x_data,    1'b0);

        // ---- pass 1 ----
        rst = 0;
        clear_len(n);
        chk32("clear_cycles", n, XD);
        ld_beat(0, 1, 5, 1, 0);
        ld_beat(0, 1, 6, 0, 0);
        ld_beat(0, 2, 9, 1, 0);
        ld_beat(1, 3, 10, 1, 1);           // beat alongside ld_done still lands
        chk1("serve_mem_ready", bus.mem_ready, 1'b1);
        chk1("serve_ld_ready",  bus.ld_ready,  1'b0);

        w_rd(1, 5, d);   chk1("w1_5",  d, 1'b1);
        w_rd(1, 6, d);   chk1("w1_6",  d, 1'b0);
        x_rd(0, 100, d); chk1("x0_100_cleared", d, 1'b0);
        x_rd(3, 10, d);  chk1("x3_10_done_beat", d, 1'b1);

        x_wr(2, 1023, 1);
        x_rd(2, 1023, d); chk1("x2_1023", d, 1'b1);
        chk1("no_req_err", bus.req_err, 1'b0);
        chk1("no_rng_err", bus.range_err, 1'b0);
        chk1("no_coll_err", bus.coll_err, 1'b0);

        // preload beat in SERVE is ignored
        ld_beat(0, 1, 5, 0, 0);
        w_rd(1, 5, d);   chk1("ld_ignored_in_serve", d, 1'b1);

        // collision: old value returned, write commits
        bus.x_sel = 1; bus.x_addr = 20; bus.wx_write = 1; bus.x_rq = 1; bus.x_wq = 1;
        @(negedge clk); bus.x_rq = 0; bus.x_wq = 0;
        @(negedge clk);
        chk1("coll_old_value", bus.x_data, 1'b0);
        chk1("coll_err_set",   bus.coll_err, 1'b1);
        x_rd(1, 20, d);  chk1("coll_write_done", d, 1'b1);

        // out-of-range weight read
        w_rd(1, WD, d);  chk1("w_oor_zero", d, 1'b0);
        chk1("range_err_set", bus.range_err, 1'b1);

        // both ports in one cycle, then hold while idle
        bus.w_sel = 2; bus.w_addr = 9; bus.w_rq = 1;
        bus.x_sel = 2; bus.x_addr = 1023; bus.x_rq = 1;
        @(negedge clk); idle();
        @(negedge clk);
        chk1("dual_w", bus.w_data, 1'b1);
        chk1("dual_x", bus.x_data, 1'b1);
        repeat (3) @(negedge clk);
        chk1("hold_w", bus.w_data, 1'b1);

        // ---- pass 2: reset mid-SERVE ----
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk1("rst2_flags", bus.req_err | bus.range_err | bus.coll_err, 1'b0);
        chk1("rst2_mem_ready", bus.mem_ready, 1'b0);
        repeat (5) @(negedge clk);
        bus.w_sel = 1; bus.w_addr = 5; bus.w_rq = 1;
        @(negedge clk); idle();
        @(negedge clk);
        chk1("clear_req_err", bus.req_err, 1'b1);
        chk1("clear_w_unchanged", bus.w_data, 1'b0);
        repeat (50) @(negedge clk);
        rst = 1;                            // restart mid-CLEAR
        @(negedge clk);
        rst = 0;
        chk1("rst3_req_err", bus.req_err, 1'b0);
        clear_len(n);
        chk32("clear_cycles_2", n, XD);

        bus.x_sel = 2; bus.x_addr = 1023; bus.x_rq = 1;
        bus.w_sel = 1; bus.w_addr = 5; bus.wx_write = 0; bus.w_wq = 1;
        @(negedge clk); idle();
        @(negedge clk);
        chk1("load_req_err", bus.req_err, 1'b1);
        chk1("load_x_unchanged", bus.x_data, 1'b0);
        ld_beat(0, 0, 5000, 1, 0);
        chk1("ld_range_err", bus.range_err, 1'b1);
        ld_beat(0, 0, 7, 1, 1);

        x_rd(2, 1023, d); chk1("x2_1023_rezeroed", d, 1'b0);
        x_rd(1, 20, d);   chk1("x1_20_rezeroed", d, 1'b0);
        x_rd(3, 10, d);   chk1("x3_10_rezeroed", d, 1'b0);
        w_rd(1, 5, d);    chk1("w1_5_kept", d, 1'b1);
        w_rd(0, 7, d);    chk1("w0_7", d, 1'b1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
